// File: rtl/peakfinder_pkg.sv
// Shared defaults and FSM encoding for the peakfinder frame scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package peakfinder_pkg;

  localparam int N_DEF         = 16;
  localparam int FRAME_LEN_DEF = 42;
  localparam int DRAIN_CYC_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/peakfinder_sched_rr_arbiter2.sv
// Two-way round-robin arbiter; remembers the last finished owner.
// Latency: grant is combinational from req; pointer updates on advance.
// Backpressure: none, caller samples grant when it is ready to start.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic [1:0] grant
);

  // last = 1 means channel 1 won last, so channel 0 is favoured next
  logic last;

  // pointer moves to the channel whose frame just finished
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (advance) begin
      last <= owner;
    end
  end

  // single requester always wins; on contention pick the non-last channel
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/peakfinder_sched.sv
// Frames two sample channels into a shared peakfinder and tags returned peaks.
// Latency: sample to pf_in_data 1 cycle; pf_out_data to peak_data 1 cycle.
// Backpressure: s*_rdy only for the granted channel in STREAM, dropped by pf_stop.
module peakfinder_sched
  import peakfinder_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [N-1:0] s0_data,
  input  logic [N-1:0] s1_data,
  input  logic         s0_valid,
  input  logic         s1_valid,
  output logic         s0_rdy,
  output logic         s1_rdy,
  output logic         pf_ready,
  output logic [N-1:0] pf_in_data,
  input  logic [N-1:0] pf_out_data,
  input  logic         pf_send_data,
  input  logic         pf_stop,
  output logic         peak_valid,
  output logic [N-1:0] peak_data,
  output logic         peak_ch,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         frame_done
);

  localparam int CW = $clog2(FRAME_LEN);
  localparam int DW = $clog2(DRAIN_CYC + 1);

  state_t          state;
  state_t          state_nxt;
  logic [1:0]      grant_q;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   dcnt;
  logic [1:0]      arb_grant;
  logic            xfer;
  logic            last_sample;
  logic            peak_take;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (state == ST_DONE),
    .owner   (grant_q[1]),
    .grant   (arb_grant)
  );

  assign xfer        = (s0_rdy & s0_valid) | (s1_rdy & s1_valid);
  assign last_sample = xfer && (cnt == CW'(FRAME_LEN - 1));
  assign peak_take   = pf_send_data && ((state == ST_STREAM) || (state == ST_DRAIN));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state: stop or a full frame ends streaming, drain is a fixed window
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|req) state_nxt = ST_STREAM;
      ST_STREAM: if (pf_stop || last_sample) state_nxt = ST_DRAIN;
      ST_DRAIN:  if (dcnt == DW'(DRAIN_CYC - 1)) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // outputs: rdy is gated by pf_stop combinationally so the stop cycle accepts nothing
  always_comb begin
    s0_rdy     = (state == ST_STREAM) && grant_q[0] && !pf_stop;
    s1_rdy     = (state == ST_STREAM) && grant_q[1] && !pf_stop;
    busy       = (state != ST_IDLE);
    frame_done = (state == ST_DONE);
    grant      = grant_q;
  end

  // frame bookkeeping: owner latched at start, counters cleared on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= 2'b00;
      cnt     <= '0;
      dcnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) grant_q <= arb_grant;
          dcnt <= '0;
        end
        ST_STREAM: begin
          if (xfer) cnt <= cnt + 1'b1;
          dcnt <= '0;
        end
        ST_DRAIN: dcnt <= dcnt + 1'b1;
        ST_DONE: begin
          cnt     <= '0;
          dcnt    <= '0;
          grant_q <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  // forward accepted samples one cycle later; data holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_ready   <= 1'b0;
      pf_in_data <= '0;
    end else begin
      pf_ready <= xfer;
      if (xfer) pf_in_data <= grant_q[1] ? s1_data : s0_data;
    end
  end

  // tag peaks that arrive while a frame is active with its owning channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_valid <= 1'b0;
      peak_data  <= '0;
      peak_ch    <= 1'b0;
    end else begin
      peak_valid <= peak_take;
      if (peak_take) begin
        peak_data <= pf_out_data;
        peak_ch   <= grant_q[1];
      end
    end
  end

endmodule

// File: tb/tb_peakfinder_sched.sv
// Randomized directed bench for peakfinder_sched with a frame-level reference model.
// Inputs are driven 1ns after the rising edge; outputs are checked on the falling edge.
// Expected values come from the bench's own frame rules, never from the DUT.
module tb_peakfinder_sched;

  localparam int FL = 42;
  localparam int DC = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] s0_data, s1_data;
  logic        s0_valid, s1_valid;
  logic        s0_rdy, s1_rdy;
  logic        pf_ready;
  logic [15:0] pf_in_data;
  logic [15:0] pf_out_data;
  logic        pf_send_data;
  logic        pf_stop;
  logic        peak_valid;
  logic [15:0] peak_data;
  logic        peak_ch;
  logic [1:0]  grant;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  // reference model of the registered outputs
  logic        m_pf_rdy;
  logic [15:0] m_pf_dat;
  logic        m_pk_v;
  logic [15:0] m_pk_d;
  logic        m_pk_ch;

  peakfinder_sched dut (
    .clk(clk), .rst(rst), .req(req),
    .s0_data(s0_data), .s1_data(s1_data),
    .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_rdy(s0_rdy), .s1_rdy(s1_rdy),
    .pf_ready(pf_ready), .pf_in_data(pf_in_data),
    .pf_out_data(pf_out_data), .pf_send_data(pf_send_data), .pf_stop(pf_stop),
    .peak_valid(peak_valid), .peak_data(peak_data), .peak_ch(peak_ch),
    .grant(grant), .busy(busy), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pf_rdy = 1'b0; m_pf_dat = '0; m_pk_v = 1'b0; m_pk_d = '0; m_pk_ch = 1'b0;
  endtask

  task automatic check_regs(input string ph);
    chk({ph, ".pf_ready"},   pf_ready,   m_pf_rdy);
    chk({ph, ".pf_in_data"}, pf_in_data, m_pf_dat);
    chk({ph, ".peak_valid"}, peak_valid, m_pk_v);
    chk({ph, ".peak_data"},  peak_data,  m_pk_d);
    chk({ph, ".peak_ch"},    peak_ch,    m_pk_ch);
  endtask

  // advance the model by one cycle given what the bench drove and what should be accepted
  task automatic upd(input bit xfer, input logic [15:0] dat, input bit pk_act, input int ch);
    m_pf_rdy = xfer;
    if (xfer) m_pf_dat = dat;
    m_pk_v = pk_act && pf_send_data;
    if (m_pk_v) begin
      m_pk_d  = pf_out_data;
      m_pk_ch = (ch == 1);
    end
  endtask

  task automatic drive(input bit v, input bit stop, input bit send, input logic [15:0] pk);
    s0_data      = 16'($urandom);
    s1_data      = 16'($urandom);
    s0_valid     = v;
    s1_valid     = v;
    pf_stop      = stop;
    pf_send_data = send;
    pf_out_data  = pk;
  endtask

  task automatic chk_all_zero(input string ph);
    chk({ph, ".s0_rdy"}, s0_rdy, 0);
    chk({ph, ".s1_rdy"}, s1_rdy, 0);
    chk({ph, ".pf_ready"}, pf_ready, 0);
    chk({ph, ".pf_in_data"}, pf_in_data, 0);
    chk({ph, ".peak_valid"}, peak_valid, 0);
    chk({ph, ".peak_data"}, peak_data, 0);
    chk({ph, ".peak_ch"}, peak_ch, 0);
    chk({ph, ".grant"}, grant, 0);
    chk({ph, ".busy"}, busy, 0);
    chk({ph, ".frame_done"}, frame_done, 0);
  endtask

  task automatic idle_cycle(input string ph);
    @(posedge clk); #1;
    req = 2'b00;
    drive(1'b1, 1'b0, 1'b1, 16'($urandom));
    @(negedge clk);
    chk({ph, ".busy"}, busy, 0);
    chk({ph, ".grant"}, grant, 0);
    chk({ph, ".frame_done"}, frame_done, 0);
    chk({ph, ".rdy"}, {s1_rdy, s0_rdy}, 0);
    check_regs(ph);
    upd(1'b0, '0, 1'b0, 0);
  endtask

  // one full frame from the IDLE cycle that raises req through the DONE cycle
  task automatic run_frame(input string nm, input logic [1:0] rq, input bit drop, input int ch,
                           input int stop_at, input bit bub, input bit drain_peak);
    int n;
    int cyc;
    bit done;
    bit v, stop, xfer;
    logic [1:0] g;
    logic [15:0] dat;
    g = (ch == 0) ? 2'b01 : 2'b10;
    // IDLE cycle: a peak offered now must be ignored
    @(posedge clk); #1;
    req = rq;
    drive(1'b1, 1'b0, 1'b1, 16'($urandom));
    @(negedge clk);
    chk({nm, ".idle_busy"}, busy, 0);
    chk({nm, ".idle_grant"}, grant, 0);
    chk({nm, ".idle_rdy"}, {s1_rdy, s0_rdy}, 0);
    check_regs({nm, ".idle"});
    upd(1'b0, '0, 1'b0, ch);
    // STREAM
    n = 0; cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); #1;
      if (drop) req = 2'b00;
      v    = bub ? (cyc % 2 == 1) : 1'b1;
      stop = (stop_at >= 0) && (n == stop_at);
      drive(v, stop, ($urandom_range(0, 3) == 0), 16'($urandom));
      @(negedge clk);
      chk({nm, ".st_grant"}, grant, g);
      chk({nm, ".st_busy"}, busy, 1);
      chk({nm, ".st_done"}, frame_done, 0);
      chk({nm, ".st_rdy"}, {s1_rdy, s0_rdy}, stop ? 2'b00 : g);
      check_regs({nm, ".st"});
      xfer = v && !stop;
      dat  = (ch == 0) ? s0_data : s1_data;
      upd(xfer, dat, 1'b1, ch);
      if (xfer) n++;
      cyc++;
      if (stop || n == FL) done = 1;
    end
    chk({nm, ".samples"}, n, (stop_at >= 0) ? stop_at : FL);
    if (bub) chk({nm, ".stream_cycles"}, cyc, 2 * FL);
    // DRAIN: exactly DC cycles, nothing accepted
    for (int d = 0; d < DC; d++) begin
      @(posedge clk); #1;
      if (drain_peak) drive(1'b1, 1'b0, (d == 1), 16'h7FF0);
      else drive(1'b1, 1'b0, ($urandom_range(0, 1) == 0), 16'($urandom));
      @(negedge clk);
      chk({nm, ".dr_busy"}, busy, 1);
      chk({nm, ".dr_done"}, frame_done, 0);
      chk({nm, ".dr_grant"}, grant, g);
      chk({nm, ".dr_rdy"}, {s1_rdy, s0_rdy}, 0);
      check_regs({nm, ".dr"});
      if (drain_peak && d == 2) begin
        chk({nm, ".drain_peak_valid"}, peak_valid, 1);
        chk({nm, ".drain_peak_data"}, peak_data, 16'h7FF0);
        chk({nm, ".drain_peak_ch"}, peak_ch, ch);
      end
      upd(1'b0, '0, 1'b1, ch);
    end
    // DONE: single pulse, peak offered here is ignored
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b1, 16'($urandom));
    @(negedge clk);
    chk({nm, ".done_pulse"}, frame_done, 1);
    chk({nm, ".done_busy"}, busy, 1);
    chk({nm, ".done_grant"}, grant, g);
    chk({nm, ".done_rdy"}, {s1_rdy, s0_rdy}, 0);
    check_regs({nm, ".done"});
    upd(1'b0, '0, 1'b0, ch);
  endtask

  initial begin
    rst = 1'b0;
    req = 2'b00;
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    #2 rst = 1'b1;
    #1 chk_all_zero("reset");
    @(posedge clk); #3 rst = 1'b0;
    idle_cycle("post_reset");

    // contention from reset: 01, 10, 01
    run_frame("rr_a", 2'b11, 1'b0, 0, -1, 1'b0, 1'b0);
    run_frame("rr_b", 2'b11, 1'b0, 1, -1, 1'b0, 1'b0);
    run_frame("rr_c", 2'b11, 1'b0, 0, -1, 1'b0, 1'b0);
    idle_cycle("rr_idle");

    // single requester, req dropped mid-frame must not abort
    run_frame("ch0_full", 2'b01, 1'b1, 0, -1, 1'b0, 1'b0);
    idle_cycle("ch0_idle");
    run_frame("ch0_stop10", 2'b01, 1'b1, 0, 10, 1'b0, 1'b0);
    idle_cycle("stop_idle");
    run_frame("ch1_drainpk", 2'b10, 1'b1, 1, -1, 1'b0, 1'b1);
    idle_cycle("pk_idle");
    run_frame("ch0_bubble", 2'b01, 1'b1, 0, -1, 1'b1, 1'b0);
    idle_cycle("bub_idle");

    // reset in the middle of a ch0 frame
    @(posedge clk); #1;
    req = 2'b01;
    drive(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      req = 2'b00;
      drive(1'b1, 1'b0, 1'b1, 16'($urandom));
    end
    @(negedge clk);
    chk("midrst.pre_busy", busy, 1);
    #1 rst = 1'b1;
    #1 chk_all_zero("midrst");
    model_reset();
    @(posedge clk); #3 rst = 1'b0;
    idle_cycle("midrst_idle0");
    idle_cycle("midrst_idle1");
    // last owner before reset was ch0, but reset must restore ch0 priority
    run_frame("post_rst_rr", 2'b11, 1'b1, 0, -1, 1'b0, 1'b0);
    idle_cycle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/peakfinder_sched.md
PEAKFINDER_SCHED -- requirements
Module: peakfinder_sched

Interface
REQ-001 Parameters SHALL be: N, 16, sample and peak width; FRAME_LEN, 42, samples per frame; DRAIN_CYC, 4, post-frame idle cycles for late peaks.
REQ-002 clk  in  1  single system clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req  in  2  per-channel frame request, level.
REQ-005 s0_data, s1_data  in  N each  signed samples, channel 0/1.
REQ-006 s0_valid, s1_valid  in  1 each  sample valid, channel 0/1.
REQ-007 s0_rdy, s1_rdy  out  1 each  sample accept, channel 0/1.
REQ-008 pf_ready  out  1  sample strobe to peakfinder.
REQ-009 pf_in_data  out  N  signed sample to peakfinder.
REQ-010 pf_out_data  in  N  peak value from peakfinder.
REQ-011 pf_send_data  in  1  peak valid from peakfinder.
REQ-012 pf_stop  in  1  early-terminate from peakfinder.
REQ-013 peak_valid  out  1  one-cycle tagged-peak strobe.
REQ-014 peak_data  out  N  captured peak value.
REQ-015 peak_ch  out  1  channel owning the captured peak.
REQ-016 grant  out  2  one-hot current frame owner, 0 when idle.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 frame_done  out  1  one-cycle end-of-frame pulse.

Function
REQ-019 FSM SHALL have states IDLE, STREAM, DRAIN, DONE.
REQ-020 IDLE: any req bit high -> register grant from round-robin arbiter, enter STREAM next cycle.
REQ-021 Arbitration SHALL be round-robin; both requesting -> channel other than last winner; pointer after reset favours channel 0.
REQ-022 STREAM: only the granted channel's s*_rdy SHALL be 1; the other SHALL be 0.
REQ-023 A transfer (valid and rdy both 1) SHALL produce pf_ready=1 and pf_in_data=sample on the following cycle (latency 1); a non-transfer cycle SHALL give pf_ready=0, pf_in_data holding last value.
REQ-024 Sample counter, width clog2(FRAME_LEN), SHALL increment per transfer; the FRAME_LEN-th transfer SHALL move STREAM->DRAIN and drop s*_rdy that same cycle.
REQ-025 pf_stop=1 in STREAM SHALL move to DRAIN next cycle, dropping s*_rdy immediately; the sample in that cycle, if transferred, is still forwarded.
REQ-026 DRAIN SHALL last exactly DRAIN_CYC cycles with pf_ready=0, then DONE.
REQ-027 DONE SHALL last one cycle: frame_done=1, arbiter pointer updated to the finished channel, counter cleared, grant cleared, -> IDLE.
REQ-028 pf_send_data=1 in STREAM or DRAIN SHALL yield peak_valid=1 next cycle with peak_data=pf_out_data and peak_ch=granted channel; ignored in IDLE/DONE.
REQ-029 req deassertion mid-frame SHALL NOT abort the frame; new req during a frame SHALL wait for IDLE.
REQ-030 Input bubbles (valid=0) SHALL stall the count with no timeout.
REQ-031 peak_data/pf_in_data SHALL pass values bit-exact, no sign extension or saturation.

Reset
REQ-032 rst=1 SHALL asynchronously force IDLE, counter 0, arbiter pointer favouring channel 0, and every output to 0.
REQ-033 rst mid-frame SHALL discard the frame with no frame_done; first post-reset grant SHALL follow REQ-021.

Structure
REQ-034 Package peakfinder_pkg SHALL hold N, FRAME_LEN, DRAIN_CYC defaults and the FSM state encoding.
REQ-035 The round-robin logic SHALL be sub-module rr_arbiter2 (req, advance, grant); the rest stays in peakfinder_sched.

Verification
REQ-036 req=01, ch0 valid continuous, 42 samples -> 42 pf_ready pulses each delayed 1 cycle, DRAIN 4 cycles, frame_done once, grant 01 throughout.
REQ-037 req=11 held over three frames -> grant sequence 01, 10, 01; s1_rdy stays 0 during ch0 frame.
REQ-038 pf_stop at sample 10 -> s0_rdy low that cycle, at most 10 samples forwarded, DRAIN 4 cycles, frame_done.
REQ-039 pf_send_data with pf_out_data=16'sh7FF0 during DRAIN of ch1 frame -> peak_valid next cycle, peak_data=7FF0, peak_ch=1.
REQ-040 valid toggling 1/0 for ch0 -> frame takes 84 STREAM cycles, count exact; rst asserted mid-STREAM -> all outputs 0 immediately, next req=11 grants ch0.
